// File: rtl/ysyx_24110015_arb_pkg.sv
// Shared types and constants for the two-master AXI4-Lite memory arbiter.
package ysyx_24110015_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFU_RD = 2'd1,
    LSU_RD = 2'd2,
    LSU_WR = 2'd3
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_IFU  = 2'b01;
  localparam logic [1:0] GNT_LSU  = 2'b10;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/ysyx_24110015_arb_pick.sv
// Combinational winner select between IFU and LSU requests.
// YSYX_24110015_ARB_RR_EN selects round-robin; otherwise LSU has fixed priority.
module ysyx_24110015_arb_pick (
  input  logic ifu_req,
  input  logic lsu_req,
`ifdef YSYX_24110015_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic pick_ifu,
  output logic pick_lsu
);

`ifdef YSYX_24110015_ARB_RR_EN
  // last_grant = 1 means the LSU was served last, so the IFU wins a tie.
  assign pick_ifu = ifu_req & (~lsu_req | last_grant);
  assign pick_lsu = lsu_req & (~ifu_req | ~last_grant);
`else
  assign pick_lsu = lsu_req;
  assign pick_ifu = ifu_req & ~lsu_req;
`endif

endmodule

// File: rtl/ysyx_24110015_mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4-Lite arbiter, one transaction in flight.
// YSYX_24110015_ARB_RR_EN enables round-robin arbitration instead of fixed LSU priority.
module ysyx_24110015_mem_arbiter
  import ysyx_24110015_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  // IFU
  input  logic [AW-1:0]   ifu_araddr,
  input  logic            ifu_arvalid,
  output logic            ifu_arready,
  output logic [DW-1:0]   ifu_rdata,
  output logic [1:0]      ifu_rresp,
  output logic            ifu_rvalid,
  input  logic            ifu_rready,
  // LSU
  input  logic [AW-1:0]   lsu_araddr,
  input  logic            lsu_arvalid,
  output logic            lsu_arready,
  output logic [DW-1:0]   lsu_rdata,
  output logic [1:0]      lsu_rresp,
  output logic            lsu_rvalid,
  input  logic            lsu_rready,
  input  logic [AW-1:0]   lsu_awaddr,
  input  logic            lsu_awvalid,
  output logic            lsu_awready,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wstrb,
  input  logic            lsu_wvalid,
  output logic            lsu_wready,
  output logic [1:0]      lsu_bresp,
  output logic            lsu_bvalid,
  input  logic            lsu_bready,
  // Slave
  output logic [AW-1:0]   m_araddr,
  output logic            m_arvalid,
  input  logic            m_arready,
  input  logic [DW-1:0]   m_rdata,
  input  logic [1:0]      m_rresp,
  input  logic            m_rvalid,
  output logic            m_rready,
  output logic [AW-1:0]   m_awaddr,
  output logic            m_awvalid,
  input  logic            m_awready,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_wstrb,
  output logic            m_wvalid,
  input  logic            m_wready,
  input  logic [1:0]      m_bresp,
  input  logic            m_bvalid,
  output logic            m_bready,
  output logic [1:0]      grant_id
);

  arb_state_e state;
  logic       aw_done;
  logic       w_done;
  logic       pick_ifu;
  logic       pick_lsu;
  logic       lsu_req;

  assign lsu_req = lsu_arvalid | lsu_awvalid | lsu_wvalid;

`ifdef YSYX_24110015_ARB_RR_EN
  logic last_grant;

  ysyx_24110015_arb_pick u_pick (
    .ifu_req    (ifu_arvalid),
    .lsu_req    (lsu_req),
    .last_grant (last_grant),
    .pick_ifu   (pick_ifu),
    .pick_lsu   (pick_lsu)
  );
`else
  ysyx_24110015_arb_pick u_pick (
    .ifu_req  (ifu_arvalid),
    .lsu_req  (lsu_req),
    .pick_ifu (pick_ifu),
    .pick_lsu (pick_lsu)
  );
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_id <= GNT_NONE;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
`ifdef YSYX_24110015_ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_lsu) begin
            state    <= lsu_arvalid ? LSU_RD : LSU_WR;
            grant_id <= GNT_LSU;
`ifdef YSYX_24110015_ARB_RR_EN
            last_grant <= 1'b1;
`endif
          end else if (pick_ifu) begin
            state    <= IFU_RD;
            grant_id <= GNT_IFU;
`ifdef YSYX_24110015_ARB_RR_EN
            last_grant <= 1'b0;
`endif
          end
        end
        IFU_RD: begin
          if (m_rvalid && ifu_rready) begin
            state    <= IDLE;
            grant_id <= GNT_NONE;
          end
        end
        LSU_RD: begin
          if (m_rvalid && lsu_rready) begin
            state    <= IDLE;
            grant_id <= GNT_NONE;
          end
        end
        LSU_WR: begin
          if (m_awvalid && m_awready) aw_done <= 1'b1;
          if (m_wvalid && m_wready)   w_done  <= 1'b1;
          // The B handshake ends the write; clearing here overrides any same-cycle set.
          if (m_bvalid && lsu_bready) begin
            state    <= IDLE;
            grant_id <= GNT_NONE;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          grant_id <= GNT_NONE;
        end
      endcase
    end
  end

  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    m_araddr    = '0;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    m_awaddr    = '0;
    m_awvalid   = 1'b0;
    m_wdata     = '0;
    m_wstrb     = '0;
    m_wvalid    = 1'b0;
    m_bready    = 1'b0;
    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = 2'b00;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = 2'b00;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bresp   = 2'b00;
    lsu_bvalid  = 1'b0;
    case (state)
      IFU_RD: begin
        m_araddr    = ifu_araddr;
        m_arvalid   = ifu_arvalid;
        ifu_arready = m_arready;
        m_rready    = ifu_rready;
        ifu_rdata   = m_rdata;
        ifu_rresp   = m_rresp;
        ifu_rvalid  = m_rvalid;
      end
      LSU_RD: begin
        m_araddr    = lsu_araddr;
        m_arvalid   = lsu_arvalid;
        lsu_arready = m_arready;
        m_rready    = lsu_rready;
        lsu_rdata   = m_rdata;
        lsu_rresp   = m_rresp;
        lsu_rvalid  = m_rvalid;
      end
      LSU_WR: begin
        m_awaddr    = lsu_awaddr;
        m_awvalid   = lsu_awvalid & ~aw_done;
        lsu_awready = m_awready & ~aw_done;
        m_wdata     = lsu_wdata;
        m_wstrb     = lsu_wstrb;
        m_wvalid    = lsu_wvalid & ~w_done;
        lsu_wready  = m_wready & ~w_done;
        m_bready    = lsu_bready;
        lsu_bresp   = m_bresp;
        lsu_bvalid  = m_bvalid;
      end
      default: ;
    endcase
  end

`ifdef SIM
  // Masters must hold a pending request until it is accepted.
  a_ifu_ar_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (ifu_arvalid && !ifu_arready) |=> ifu_arvalid);
  a_lsu_ar_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (lsu_arvalid && !lsu_arready) |=> lsu_arvalid);
  a_lsu_aw_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (lsu_awvalid && !lsu_awready && !aw_done) |=> lsu_awvalid);
  a_lsu_w_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (lsu_wvalid && !lsu_wready && !w_done) |=> lsu_wvalid);
`endif

endmodule

// File: tb/tb_ysyx_24110015_mem_arbiter.sv
// Directed bench for the memory arbiter; inputs change on the falling edge, outputs are checked 1ns later.
module tb_ysyx_24110015_mem_arbiter;
  import ysyx_24110015_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   ifu_araddr, lsu_araddr, lsu_awaddr, m_araddr, m_awaddr;
  logic            ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic [DW-1:0]   ifu_rdata, lsu_rdata, lsu_wdata, m_rdata, m_wdata;
  logic [1:0]      ifu_rresp, lsu_rresp, lsu_bresp, m_rresp, m_bresp, grant_id;
  logic            lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic            lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready;
  logic            lsu_bvalid, lsu_bready;
  logic [DW/8-1:0] lsu_wstrb, m_wstrb;
  logic            m_arvalid, m_arready, m_rvalid, m_rready;
  logic            m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;

  int          checks = 0;
  int          errors = 0;
  logic        exp_last;
  logic        first_ifu;
  logic [31:0] mem_word;

  always #5 clk = ~clk;

  ysyx_24110015_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
    .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .grant_id(grant_id)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    ifu_araddr = '0; ifu_arvalid = 1'b0; ifu_rready = 1'b0;
    lsu_araddr = '0; lsu_arvalid = 1'b0; lsu_rready = 1'b0;
    lsu_awaddr = '0; lsu_awvalid = 1'b0; lsu_wdata = '0; lsu_wstrb = '0;
    lsu_wvalid = 1'b0; lsu_bready = 1'b0;
    m_arready = 1'b0; m_rdata = '0; m_rresp = OKAY; m_rvalid = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bresp = OKAY; m_bvalid = 1'b0;
  endtask

  // Request already presented by the caller during the preceding IDLE cycle.
  task automatic read_txn(input logic [1:0] gnt, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] resp, input string tag);
    @(negedge clk); #1;
    check({tag, ":grant"}, 32'(grant_id), 32'(gnt));
    check({tag, ":m_arvalid"}, 32'(m_arvalid), 1);
    check({tag, ":m_araddr"}, m_araddr, addr);
    m_arready = 1'b1; #1;
    if (gnt == GNT_IFU) begin
      check({tag, ":ifu_arready"}, 32'(ifu_arready), 1);
      check({tag, ":lsu_arready"}, 32'(lsu_arready), 0);
    end else begin
      check({tag, ":lsu_arready"}, 32'(lsu_arready), 1);
      check({tag, ":ifu_arready"}, 32'(ifu_arready), 0);
    end
    @(negedge clk);
    m_arready = 1'b0;
    if (gnt == GNT_IFU) begin ifu_arvalid = 1'b0; ifu_rready = 1'b1; end
    else                begin lsu_arvalid = 1'b0; lsu_rready = 1'b1; end
    m_rvalid = 1'b1; m_rdata = data; m_rresp = resp; #1;
    check({tag, ":m_arvalid_after"}, 32'(m_arvalid), 0);
    check({tag, ":m_rready"}, 32'(m_rready), 1);
    if (gnt == GNT_IFU) begin
      check({tag, ":ifu_rvalid"}, 32'(ifu_rvalid), 1);
      check({tag, ":ifu_rdata"}, ifu_rdata, data);
      check({tag, ":ifu_rresp"}, 32'(ifu_rresp), 32'(resp));
      check({tag, ":lsu_rvalid"}, 32'(lsu_rvalid), 0);
    end else begin
      check({tag, ":lsu_rvalid"}, 32'(lsu_rvalid), 1);
      check({tag, ":lsu_rdata"}, lsu_rdata, data);
      check({tag, ":lsu_rresp"}, 32'(lsu_rresp), 32'(resp));
      check({tag, ":ifu_rvalid"}, 32'(ifu_rvalid), 0);
    end
    @(negedge clk);
    m_rvalid = 1'b0; m_rdata = '0; m_rresp = OKAY; ifu_rready = 1'b0; lsu_rready = 1'b0; #1;
    check({tag, ":grant_idle"}, 32'(grant_id), 32'(GNT_NONE));
    check({tag, ":m_arvalid_idle"}, 32'(m_arvalid), 0);
  endtask

  task automatic pair_txn(input string tag);
    @(negedge clk);
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0004;
    lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_1000; #1;
    check({tag, ":req_idle"}, 32'(m_arvalid), 0);
`ifdef YSYX_24110015_ARB_RR_EN
    first_ifu = exp_last;
`else
    first_ifu = 1'b0;
`endif
    if (first_ifu) begin
      read_txn(GNT_IFU, 32'h8000_0004, 32'h0040_0093, OKAY, {tag, ".ifu"});
      read_txn(GNT_LSU, 32'h8000_1000, 32'h1234_5678, OKAY, {tag, ".lsu"});
      exp_last = 1'b1;
    end else begin
      read_txn(GNT_LSU, 32'h8000_1000, 32'h1234_5678, OKAY, {tag, ".lsu"});
      read_txn(GNT_IFU, 32'h8000_0004, 32'h0040_0093, OKAY, {tag, ".ifu"});
      exp_last = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_last = 1'b1;
    mem_word = '0;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("rst:grant", 32'(grant_id), 32'(GNT_NONE));
    check("rst:m_arvalid", 32'(m_arvalid), 0);
    check("rst:m_awvalid", 32'(m_awvalid), 0);
    check("rst:m_wvalid", 32'(m_wvalid), 0);
    check("rst:m_rready", 32'(m_rready), 0);
    check("rst:m_bready", 32'(m_bready), 0);
    check("rst:ifu_arready", 32'(ifu_arready), 0);
    check("rst:lsu_rdata", lsu_rdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous reads; order depends on arbitration mode.
    pair_txn("pairA");

    // IFU alone: visible on m_ar one cycle after the request.
    @(negedge clk);
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0000; #1;
    check("ifu1:grant_N", 32'(grant_id), 32'(GNT_NONE));
    check("ifu1:m_arvalid_N", 32'(m_arvalid), 0);
    read_txn(GNT_IFU, 32'h8000_0000, 32'h0000_0413, OKAY, "ifu1");
    exp_last = 1'b0;

    pair_txn("pairB");

    // LSU write: AW accepted two cycles before W.
    @(negedge clk);
    lsu_awvalid = 1'b1; lsu_awaddr = 32'h8000_2000;
    lsu_wvalid = 1'b1; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF; #1;
    check("wr:m_awvalid_idle", 32'(m_awvalid), 0);
    @(negedge clk); #1;
    check("wr:grant", 32'(grant_id), 32'(GNT_LSU));
    check("wr:m_awvalid", 32'(m_awvalid), 1);
    check("wr:m_awaddr", m_awaddr, 32'h8000_2000);
    check("wr:m_wvalid", 32'(m_wvalid), 1);
    check("wr:m_wstrb", 32'(m_wstrb), 32'hF);
    check("wr:m_arvalid", 32'(m_arvalid), 0);
    m_awready = 1'b1; #1;
    check("wr:lsu_awready", 32'(lsu_awready), 1);
    check("wr:lsu_wready", 32'(lsu_wready), 0);
    @(negedge clk); #1;
    check("wr:m_awvalid_done", 32'(m_awvalid), 0);
    check("wr:lsu_awready_done", 32'(lsu_awready), 0);
    check("wr:m_wvalid_wait", 32'(m_wvalid), 1);
    lsu_awvalid = 1'b0; m_awready = 1'b0;
    @(negedge clk);
    m_wready = 1'b1; #1;
    check("wr:lsu_wready", 32'(lsu_wready), 1);
    if (m_wvalid && m_wready) mem_word = m_wdata;
    @(negedge clk);
    m_bvalid = 1'b1; m_bresp = OKAY; lsu_bready = 1'b1; #1;
    check("wr:m_wvalid_done", 32'(m_wvalid), 0);
    check("wr:lsu_wready_done", 32'(lsu_wready), 0);
    check("wr:lsu_bvalid", 32'(lsu_bvalid), 1);
    check("wr:lsu_bresp", 32'(lsu_bresp), 32'(OKAY));
    check("wr:m_bready", 32'(m_bready), 1);
    @(negedge clk);
    lsu_wvalid = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; lsu_bready = 1'b0; #1;
    check("wr:grant_idle", 32'(grant_id), 32'(GNT_NONE));
    check("wr:lsu_bvalid_idle", 32'(lsu_bvalid), 0);
    check("wr:mem", mem_word, 32'hDEAD_BEEF);

    // DECERR passes through, then a normal IFU read.
    @(negedge clk);
    lsu_arvalid = 1'b1; lsu_araddr = 32'h0000_0000; #1;
    read_txn(GNT_LSU, 32'h0000_0000, 32'h0000_0000, DECERR, "decerr");
    @(negedge clk);
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0008; #1;
    read_txn(GNT_IFU, 32'h8000_0008, 32'h0010_0093, OKAY, "after_decerr");

    // Reset while in LSU_WR with aw_done set.
    @(negedge clk);
    lsu_awvalid = 1'b1; lsu_awaddr = 32'h8000_3000;
    lsu_wvalid = 1'b1; lsu_wdata = 32'h5555_AAAA; lsu_wstrb = 4'h3;
    @(negedge clk);
    m_awready = 1'b1;
    @(negedge clk);
    lsu_awvalid = 1'b0; m_awready = 1'b0; #1;
    check("rst6:m_awvalid_done", 32'(m_awvalid), 0);
    check("rst6:m_wvalid_pending", 32'(m_wvalid), 1);
    rst_n = 1'b0; #1;
    check("rst6:m_awvalid", 32'(m_awvalid), 0);
    check("rst6:m_wvalid", 32'(m_wvalid), 0);
    check("rst6:m_arvalid", 32'(m_arvalid), 0);
    check("rst6:grant", 32'(grant_id), 32'(GNT_NONE));
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1; #1;
    check("rst6:grant_after", 32'(grant_id), 32'(GNT_NONE));
    @(negedge clk);
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0000; #1;
    read_txn(GNT_IFU, 32'h8000_0000, 32'h0000_0413, OKAY, "post_rst");

    // A fresh write after reset must see aw_done cleared.
    @(negedge clk);
    lsu_awvalid = 1'b1; lsu_awaddr = 32'h8000_4000;
    lsu_wvalid = 1'b1; lsu_wdata = 32'h0BAD_F00D; lsu_wstrb = 4'hF;
    @(negedge clk); #1;
    check("post_rst_wr:m_awvalid", 32'(m_awvalid), 1);
    check("post_rst_wr:m_wvalid", 32'(m_wvalid), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
